// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_flex
//  Brief    : Single-clock FIFO with arbitrary depth, selectable registered or
//             first-word-fall-through read, almost-full/almost-empty flags,
//             occupancy count, synchronous flush and sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_flex #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 128,
    parameter int DEPTH         = 11,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_flush,
    input  logic                  fifo_write_e,
    input  logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_read_e,
    output logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_afull,
    output logic                  fifo_aempty,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  fifo_ready,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    // Pointers only need to span the real storage, not the full address space
    localparam int                    c_PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0]    c_PTR_LAST   = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [ADDR_WIDTH:0]   c_LVL_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_LVL_FULL   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_LVL_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   c_LVL_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    if ((DEPTH > (1 << ADDR_WIDTH)) || (DEPTH < 2)) begin : g_bad_depth
        $error("fifo_flex: DEPTH must lie in 2..2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [ADDR_WIDTH:0]   w_level_nxt;
    logic                  r_ready;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_full;
    logic                  r_afull;
    logic                  r_aempty;

    logic                  w_flush;
    logic                  w_cmd_ok;
    logic                  w_can_read;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ram_pop;
    logic [DATA_WIDTH-1:0] w_ram_q;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
    endfunction

    // Flush and commands are only honoured once the block reports ready;
    // a flush swallows any read or write issued alongside it.
    assign w_flush  = r_ready & fifo_flush & ~reset;
    assign w_cmd_ok = r_ready & ~fifo_flush & ~reset;
    assign w_rd_acc = w_cmd_ok & fifo_read_e & w_can_read;
    assign w_wr_acc = w_cmd_ok & fifo_write_e & (~r_full | w_rd_acc);
    assign w_ram_q  = r_mem[r_rptr];

    // Next occupancy; reset and flush both return it to zero
    always_comb begin
        w_level_nxt = r_level;
        if (reset || w_flush) begin
            w_level_nxt = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + c_LVL_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_level_nxt = r_level - c_LVL_ONE;
        end
    end

    // Storage write port; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= fifo_wdata;
        end
    end

    // Pointers, ready handshake and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ready     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ready     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_wr_acc) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_ram_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_cmd_ok && fifo_write_e && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (w_cmd_ok && fifo_read_e && !w_can_read) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Level and threshold flags come from the same next-state value so they stay coherent
    always_ff @(posedge clk) begin
        r_level  <= w_level_nxt;
        r_full   <= (w_level_nxt == c_LVL_FULL);
        r_afull  <= (w_level_nxt >= c_LVL_AFULL);
        r_aempty <= (w_level_nxt <= c_LVL_AEMPTY);
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] r_rdata;
        logic                  r_lvl_zero;

        assign w_can_read = (r_level != '0);
        assign w_ram_pop  = w_rd_acc;

        // Popped word lands in the output register on the accepting edge
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
            end else if (w_rd_acc) begin
                r_rdata <= w_ram_q;
            end
        end

        // Empty tracks the stored count directly in this mode
        always_ff @(posedge clk) begin
            r_lvl_zero <= (w_level_nxt == '0);
        end

        assign fifo_rdata = r_rdata;
        assign fifo_empty = r_lvl_zero;
    end else begin : g_fwft_read
        // Two-stage prefetch: stage A captures the RAM head, stage B is the
        // displayed word. Keeping A full lets back-to-back pops run bubble-free.
        logic [DATA_WIDTH-1:0] r_a_data;
        logic [DATA_WIDTH-1:0] r_b_data;
        logic                  r_a_valid;
        logic                  r_b_valid;
        logic                  w_b_load;
        logic                  w_a_take;
        logic [ADDR_WIDTH:0]   w_ram_cnt;

        assign w_can_read = r_b_valid;
        assign w_b_load   = ~r_b_valid | w_rd_acc;
        assign w_a_take   = ~r_a_valid | w_b_load;
        assign w_ram_cnt  = r_level - {{ADDR_WIDTH{1'b0}}, r_a_valid}
                                    - {{ADDR_WIDTH{1'b0}}, r_b_valid};
        assign w_ram_pop  = w_a_take & (w_ram_cnt != '0) & ~reset & ~w_flush;

        // Advance the prefetch pipeline whenever a stage frees up
        always_ff @(posedge clk) begin
            if (reset) begin
                r_a_valid <= 1'b0;
                r_b_valid <= 1'b0;
                r_a_data  <= '0;
                r_b_data  <= '0;
            end else if (w_flush) begin
                r_a_valid <= 1'b0;
                r_b_valid <= 1'b0;
            end else begin
                if (w_b_load) begin
                    r_b_valid <= r_a_valid;
                    if (r_a_valid) begin
                        r_b_data <= r_a_data;
                    end
                end
                if (w_a_take) begin
                    r_a_valid <= w_ram_pop;
                    if (w_ram_pop) begin
                        r_a_data <= w_ram_q;
                    end
                end
            end
        end

        assign fifo_rdata = r_b_data;
        assign fifo_empty = ~r_b_valid;
    end

    assign fifo_full      = r_full;
    assign fifo_afull     = r_afull;
    assign fifo_aempty    = r_aempty;
    assign fifo_level     = r_level;
    assign fifo_ready     = r_ready;
    assign fifo_overflow  = r_overflow;
    assign fifo_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_flex
//  Brief    : Self-checking bench for fifo_flex in registered-read and FWFT
//             modes against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_flex;

    localparam int DW    = 128;
    localparam int AW    = 9;
    localparam int DEPTH = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          fl0 = 0, we0 = 0, re0 = 0, fl1 = 0, we1 = 0, re1 = 0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic [DW-1:0] rd0, rd1;
    logic          full0, empty0, afull0, aempty0, ready0, ov0, uf0;
    logic          full1, empty1, afull1, aempty1, ready1, ov1, uf1;
    logic [AW:0]   lvl0, lvl1;

    fifo_flex #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut_reg (
        .clk(clk), .reset(reset), .fifo_flush(fl0), .fifo_write_e(we0),
        .fifo_wdata(wd0), .fifo_read_e(re0), .fifo_rdata(rd0), .fifo_full(full0),
        .fifo_empty(empty0), .fifo_afull(afull0), .fifo_aempty(aempty0),
        .fifo_level(lvl0), .fifo_ready(ready0), .fifo_overflow(ov0),
        .fifo_underflow(uf0)
    );

    fifo_flex #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_dut_fwft (
        .clk(clk), .reset(reset), .fifo_flush(fl1), .fifo_write_e(we1),
        .fifo_wdata(wd1), .fifo_read_e(re1), .fifo_rdata(rd1), .fifo_full(full1),
        .fifo_empty(empty1), .fifo_afull(afull1), .fifo_aempty(aempty1),
        .fifo_level(lvl1), .fifo_ready(ready1), .fifo_overflow(ov1),
        .fifo_underflow(uf1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit            mode = 1'b0;
    int            n_edge = 0;
    logic [DW-1:0] q[$];
    int            tq[$];
    bit            m_ready = 0, m_ov = 0, m_uf = 0, m_vis = 0;
    logic [DW-1:0] m_rdata0 = '0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the abstract FIFO: a queue of words, each stamped with
    // the edge that wrote it. In FWFT mode the head is visible two edges later.
    task automatic model_edge(input logic r, input logic we, input logic re,
                              input logic fl, input logic [DW-1:0] wd);
        bit can_rd, rd, wr;
        n_edge++;
        if (r) begin
            q.delete(); tq.delete();
            m_ready = 0; m_ov = 0; m_uf = 0; m_rdata0 = '0;
        end else begin
            can_rd = mode ? m_vis : (q.size() > 0);
            if (m_ready && fl) begin
                q.delete(); tq.delete();
                m_ov = 0; m_uf = 0; m_ready = 0;
            end else begin
                if (m_ready) begin
                    rd = re && can_rd;
                    wr = we && ((q.size() < DEPTH) || rd);
                    if (re && !can_rd) m_uf = 1;
                    if (we && !wr) m_ov = 1;
                    if (rd) begin
                        if (!mode) m_rdata0 = q[0];
                        void'(q.pop_front());
                        void'(tq.pop_front());
                    end
                    if (wr) begin
                        q.push_back(wd);
                        tq.push_back(n_edge);
                    end
                end
                m_ready = 1;
            end
        end
        m_vis = 0;
        if (q.size() > 0) m_vis = (tq[0] <= n_edge - 2);
    endtask

    task automatic check_all();
        logic [AW:0]   lvl;
        logic          f, af, ae, em, rdy, ov, uf;
        logic [DW-1:0] rd;
        int            sz;
        if (mode) begin
            lvl = lvl1; f = full1; af = afull1; ae = aempty1; em = empty1;
            rdy = ready1; ov = ov1; uf = uf1; rd = rd1;
        end else begin
            lvl = lvl0; f = full0; af = afull0; ae = aempty0; em = empty0;
            rdy = ready0; ov = ov0; uf = uf0; rd = rd0;
        end
        sz = q.size();
        check_eq("level", DW'(lvl), DW'(sz));
        check_eq("full", DW'(f), DW'(sz == DEPTH));
        check_eq("afull", DW'(af), DW'(sz >= DEPTH - 2));
        check_eq("aempty", DW'(ae), DW'(sz <= 2));
        check_eq("empty", DW'(em), DW'(mode ? !m_vis : (sz == 0)));
        check_eq("ready", DW'(rdy), DW'(m_ready));
        check_eq("overflow", DW'(ov), DW'(m_ov));
        check_eq("underflow", DW'(uf), DW'(m_uf));
        if (!mode) check_eq("rdata_reg", rd, m_rdata0);
        else if (m_vis) check_eq("rdata_fwft", rd, q[0]);
    endtask

    task automatic cycle(input logic we, input logic re, input logic fl, input logic [DW-1:0] wd);
        we0 = 0; re0 = 0; fl0 = 0; wd0 = '0;
        we1 = 0; re1 = 0; fl1 = 0; wd1 = '0;
        if (mode) begin
            we1 = we; re1 = re; fl1 = fl; wd1 = wd;
        end else begin
            we0 = we; re0 = re; fl0 = fl; wd0 = wd;
        end
        @(posedge clk);
        model_edge(reset, we, re, fl, wd);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle(0, 0, 0, '0);
        reset = 1'b0;
    endtask

    task automatic rand_run(input int n, input int wr_pct, input int rd_pct);
        logic [DW-1:0] wd;
        for (int i = 0; i < n; i++) begin
            wd = {$urandom, $urandom, $urandom, $urandom};
            cycle(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
                  ($urandom_range(0, 59) == 0), wd);
        end
    endtask

    initial begin
        // ---------------- registered-read mode ----------------
        mode = 1'b0;
        do_reset(2);
        check_eq("rst_rdata", rd0, '0);
        check_eq("rst_ready", DW'(ready0), '0);
        cycle(1, 0, 0, 128'hdead);              // ignored: not ready yet
        check_eq("notready_lvl", DW'(lvl0), '0);
        for (int i = 1; i <= 11; i++) cycle(1, 0, 0, DW'(i));
        check_eq("fill_lvl", DW'(lvl0), DW'(11));
        check_eq("fill_full", DW'(full0), DW'(1));
        cycle(1, 0, 0, DW'(12));
        check_eq("ovf_flag", DW'(ov0), DW'(1));
        check_eq("ovf_lvl", DW'(lvl0), DW'(11));
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, '0);
        check_eq("drain_last", rd0, DW'(11));
        check_eq("drain_empty", DW'(empty0), DW'(1));
        cycle(0, 1, 0, '0);
        check_eq("udf_flag", DW'(uf0), DW'(1));
        cycle(0, 0, 1, '0);
        cycle(0, 0, 0, '0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, DW'(100 + i));
        for (int i = 0; i < 50; i++) cycle(1, 1, 0, DW'(200 + i));
        check_eq("stream_lvl", DW'(lvl0), DW'(3));
        for (int i = 0; i < 20 && q.size() < DEPTH; i++) cycle(1, 0, 0, DW'(300 + i));
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, DW'(400 + i));
        check_eq("passthru_ovf", DW'(ov0), '0);
        check_eq("passthru_lvl", DW'(lvl0), DW'(11));
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, '0);
        check_eq("passthru_word", rd0, DW'(404));
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, DW'(500 + i));
        cycle(1, 0, 1, 128'h999);
        check_eq("flush_lvl", DW'(lvl0), '0);
        check_eq("flush_ready", DW'(ready0), '0);
        check_eq("flush_empty", DW'(empty0), DW'(1));
        cycle(1, 0, 0, 128'h777);               // dropped: ready low after flush
        cycle(1, 0, 0, 128'h555);
        cycle(0, 1, 0, '0);
        check_eq("post_flush_first", rd0, 128'h555);
        rand_run(400, 50, 50);
        reset = 1'b1;
        cycle(1, 1, 0, 128'h1);
        reset = 1'b0;
        rand_run(150, 60, 40);

        // ---------------- first-word-fall-through mode ----------------
        mode = 1'b1;
        do_reset(2);
        cycle(0, 0, 0, '0);
        cycle(1, 0, 0, 128'hA5);
        check_eq("fwft_e0", DW'(empty1), DW'(1));
        cycle(0, 0, 0, '0);
        check_eq("fwft_e1", DW'(empty1), DW'(1));
        cycle(0, 0, 0, '0);
        check_eq("fwft_e2", DW'(empty1), '0);
        check_eq("fwft_a5", rd1, 128'hA5);
        cycle(1, 0, 0, 128'hB1);
        cycle(1, 0, 0, 128'hB2);
        cycle(1, 0, 0, 128'hB3);
        repeat (3) cycle(0, 0, 0, '0);
        cycle(0, 1, 0, '0);
        check_eq("pop_b1", rd1, 128'hB1);
        check_eq("pop_b1_vld", DW'(empty1), '0);
        cycle(0, 1, 0, '0);
        check_eq("pop_b2", rd1, 128'hB2);
        cycle(0, 1, 0, '0);
        check_eq("pop_b3", rd1, 128'hB3);
        check_eq("pop_b3_vld", DW'(empty1), '0);
        cycle(0, 1, 0, '0);
        check_eq("pop_done", DW'(empty1), DW'(1));
        rand_run(300, 70, 30);
        rand_run(300, 50, 80);
        reset = 1'b1;
        cycle(1, 1, 0, 128'h2);
        reset = 1'b0;
        rand_run(200, 60, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
